// File: rtl/gcd_pkg.sv
// Shared definitions for the binary-GCD (Stein) engine: FSM encoding and the
// iteration bound used by the termination check.
package gcd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReduce = 2'd1,
    StDone   = 2'd2
  } gcd_state_e;

  // Upper bound on REDUCE cycles for one problem.
  function automatic int unsigned step_bound(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational Stein iteration: strips common or single factors of two,
// or replaces the larger odd operand by half the difference.
module gcd_stein_step #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             eq
);

  assign eq = (a == b);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    if (!eq) begin
      if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a > b) begin
        // Both odd: the difference is even, so halving it loses nothing.
        a_nxt = (a - b) >> 1;
      end else begin
        b_nxt = (b - a) >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_stein_unit.sv
// Binary-GCD engine with valid/ready operand and result handshakes; reports the
// number of REDUCE cycles spent and short-circuits zero operands.
module gcd_stein_unit
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = $clog2(2 * WIDTH + 2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_data,
  input  logic [WIDTH-1:0]  b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  d_out,
  output logic [STEP_W-1:0] steps,
  output logic              busy
);

  localparam int unsigned KW = $clog2(WIDTH);

  gcd_state_e        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, d_out_q, d_out_d;
  logic [KW-1:0]     k_q, k_d;
  logic [STEP_W-1:0] step_q, step_d, steps_q, steps_d;
  logic              in_ready_q, out_valid_q, busy_q;

  logic [WIDTH-1:0]  a_nxt, b_nxt;
  logic [KW-1:0]     k_nxt;
  logic              eq;

  gcd_stein_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .a     (a_q),
    .b     (b_q),
    .k     (k_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .k_nxt (k_nxt),
    .eq    (eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    step_d  = step_q;
    d_out_d = d_out_q;
    steps_d = steps_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_d    = a_data;
          b_d    = b_data;
          k_d    = '0;
          step_d = '0;
          if (a_data == '0 || b_data == '0) begin
            d_out_d = a_data | b_data;
            steps_d = '0;
            state_d = StDone;
          end else begin
            state_d = StReduce;
          end
        end
      end
      StReduce: begin
        step_d = step_q + STEP_W'(1);
        if (eq) begin
          d_out_d = a_q << k_q;
          steps_d = step_q + STEP_W'(1);
          state_d = StDone;
        end else begin
          a_d = a_nxt;
          b_d = b_nxt;
          k_d = k_nxt;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake/status flags are registered from the next state so they are glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      step_q      <= '0;
      d_out_q     <= '0;
      steps_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      step_q      <= step_d;
      d_out_q     <= d_out_d;
      steps_q     <= steps_d;
      in_ready_q  <= (state_d == StIdle);
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d_out     = d_out_q;
  assign steps     = steps_q;
  assign busy      = busy_q;

  step_bound_chk : assert property (@(posedge clock) disable iff (!reset)
    (state_q == StReduce) |-> (step_q < STEP_W'(step_bound(WIDTH))));

endmodule

// File: doc/gcd_stein_unit.md
Name: gcd_stein_unit

Overview:
Parametrised binary-GCD (Stein) engine. Successor to the fixed 4-bit unified GCD datapath.
- Operand width is generic.
- Accepts operands through a valid/ready handshake and returns the result through a valid/ready handshake.
- Reports the iteration count and handles zero operands explicitly.
- Sits between an operand producer (CPU register block or testbench driver) and a result consumer. Operates one problem at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2)
- STEP_W, $clog2(2*WIDTH+2), width of the iteration counter output

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands
- a_data  in  WIDTH  operand A
- b_data  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- d_out  out  WIDTH  GCD result
- steps  out  STEP_W  number of REDUCE cycles spent on this problem
- busy  out  1  high in REDUCE and DONE

Behaviour:
- Reset (reset=0, async): state=IDLE. in_ready=0 while reset is asserted; in_ready=1 in the first IDLE cycle after release. out_valid=0, d_out=0, steps=0, busy=0. Internal a, b, k (common power of two) and step counter are cleared. Reset mid-operation aborts the problem with no output.
- States: IDLE, REDUCE, DONE. Registered outputs only.
- IDLE: in_ready=1. Handshake when in_valid&&in_ready at a rising edge: latch a=a_data, b=b_data, k=0, step=0.
  - If a_data==0 or b_data==0: d_out=a_data|b_data, steps=0, go to DONE. GCD(0,0)=0.
  - Otherwise go to REDUCE.
- REDUCE: one rule per cycle, evaluated in priority order. step increments in every REDUCE cycle, including the terminating one.
  1. a==b: d_out=a<<k, steps=step+1, go to DONE.
  2. a and b both even: a>>=1, b>>=1, k+=1.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. both odd, a>b: a=(a-b)>>1; else b=(b-a)>>1.
- Width rules:
  - Subtraction is WIDTH bits and never underflows because of the comparison.
  - a<<k fits in WIDTH because the result never exceeds min(a_data,b_data).
  - k width is $clog2(WIDTH).
- Termination bound: REDUCE lasts at most 2*WIDTH cycles. This is a verification assertion.
- DONE: out_valid=1, and d_out and steps are held stable until out_ready=1. On handshake: out_valid=0, go to IDLE. A new operand is accepted no earlier than the following cycle.
- in_ready=0 in REDUCE and DONE. in_valid is ignored there, and a_data/b_data changes have no effect.
- Latency: from the accept edge, out_valid rises after (REDUCE cycles) edges. A zero operand takes 1 edge.
- d_out holds its last result in IDLE and is cleared only by reset.

Decomposition:
- Shared package gcd_pkg holds:
  - state encoding (IDLE=2'd0, REDUCE=2'd1, DONE=2'd2)
  - the step-bound function 2*WIDTH used by assertions
- Sub-module gcd_stein_step: purely combinational single iteration. Inputs a, b, k. Outputs next a, b, k and eq flag. Parametrised by WIDTH.
- The top level holds the FSM, registers and handshakes.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles, release. Required: in_ready=1 in the first IDLE cycle after release; out_valid=0, d_out=0, steps=0 throughout reset.
- WIDTH=4, a=15, b=13, out_ready=1. Required: d_out=1, steps=5, out_valid for exactly one cycle.
- WIDTH=4, a=6, b=3 -> d_out=3, steps=2. Same operands with a=3, b=6 -> d_out=3.
- WIDTH=8, a=12, b=8. Required: d_out=4, steps=5, which exercises the k shift. Then a=0, b=9 -> d_out=9, steps=0, one-edge latency. Then a=0, b=0 -> d_out=0.
- Backpressure: out_ready=0 for 10 cycles in DONE. Required: out_valid, d_out and steps stay stable, in_ready=0, and a new in_valid is ignored.
- Reset asserted mid-REDUCE (a=255, b=170) -> immediate IDLE with outputs cleared. A following problem a=255, b=170 -> d_out=85.
